// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states and
// the little-endian byte-lane enable used by byte stores.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int BYTE_LANES = 4;

  function automatic logic [BYTE_LANES-1:0] lane_mask(input logic [1:0] i_lane);
    return 4'b0001 << i_lane;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Processor data-port bus: request fields from the memory stage and the
// responder's ready/err/rdata answer plus the combinational stall.
interface dmem_if;
  logic        req;
  logic        we;
  logic        sb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, we, sb, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, sb, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/dmem_byte_merge.sv
// Merges store data into the old word lane by lane; word stores pass an
// all-ones mask, byte stores a single-lane mask.
module dmem_byte_merge
  import dmem_pkg::*;
(
  input  logic [31:0]           i_old,
  input  logic [31:0]           i_data,
  input  logic [BYTE_LANES-1:0] i_mask,
  output logic [31:0]           o_word
);

  always_comb begin
    o_word = i_old;
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (i_mask[i]) o_word[8*i +: 8] = i_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with LATENCY wait states: word load, word store and
// byte store over a request/ready handshake, stalling the pipeline via busy.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter  int DEPTH   = 64,
  parameter  int LATENCY = 2,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    reset,
  dmem_if.slave   bus
);

  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic        r_sb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic                  w_idle;
  logic                  w_we;
  logic                  w_sb;
  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_misalign;
  logic [BYTE_LANES-1:0] w_mask;
  logic [31:0]           w_storeData;
  logic [31:0]           w_oldWord;
  logic [31:0]           w_newWord;
  logic                  w_enterDone;
  logic                  w_commit;
  logic                  w_unused;

  // In IDLE the live bus is used so a zero-latency build can answer on the
  // accept edge; afterwards only the latched request fields matter.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_we        = w_idle ? bus.we    : r_we;
  assign w_sb        = w_idle ? bus.sb    : r_sb;
  assign w_addr      = w_idle ? bus.addr  : r_addr;
  assign w_wdata     = w_idle ? bus.wdata : r_wdata;
  assign w_idx       = w_addr[IDX_W+1:2];
  assign w_misalign  = !w_sb && (w_addr[1:0] != 2'b00);
  assign w_mask      = w_sb ? lane_mask(w_addr[1:0]) : 4'hF;
  assign w_storeData = w_sb ? {BYTE_LANES{w_wdata[7:0]}} : w_wdata;
  assign w_oldWord   = r_mem[w_idx];
  assign w_unused    = ^w_addr[31:IDX_W+2];

  assign w_enterDone = ((r_state == ST_WAIT) && (r_cnt == 4'd0)) ||
                       ((LATENCY == 0) && w_idle && bus.req);
  assign w_commit    = reset && w_enterDone && w_we && !w_misalign;

  dmem_byte_merge u_merge (
    .i_old  (w_oldWord),
    .i_data (w_storeData),
    .i_mask (w_mask),
    .o_word (w_newWord)
  );

  always_ff @(posedge clk) begin
    if (w_commit) r_mem[w_idx] <= w_newWord;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_sb    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_sb    <= bus.sb;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            if (LATENCY == 0) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) r_state <= ST_DONE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_enterDone) begin
        r_ready <= 1'b1;
        r_err   <= w_misalign;
        r_rdata <= (!w_we && !w_misalign) ? w_oldWord : 32'd0;
      end else begin
        r_ready <= 1'b0;
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.busy  = bus.req & ~r_ready;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main
// behaviour and a LATENCY=0 instance for the zero-wait-state timing.
module tb_dmem_responder;

  logic clk;
  logic reset;
  int   totalChecks;
  int   badChecks;

  dmem_if ifA ();
  dmem_if ifB ();

  dmem_responder #(.DEPTH(64), .LATENCY(2)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (ifA)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic driveBus(input bit useB, input logic req, input logic we, input logic sb,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (useB) begin
      ifB.req = req; ifB.we = we; ifB.sb = sb; ifB.addr = addr; ifB.wdata = wdata;
    end else begin
      ifA.req = req; ifA.we = we; ifA.sb = sb; ifA.addr = addr; ifA.wdata = wdata;
    end
  endtask

  // One full handshake: request at a falling edge, hold until ready is seen.
  task automatic applyStimulus(input bit useB, input logic we, input logic sb,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rd, output logic er,
                               output int cyc, output int busyCnt);
    bit got;
    got = 0; cyc = 0; busyCnt = 0; rd = '0; er = 1'b0;
    @(negedge clk);
    driveBus(useB, 1'b1, we, sb, addr, wdata);
    #1;
    if (useB ? ifB.busy : ifA.busy) busyCnt++;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      cyc++;
      if (useB ? ifB.ready : ifA.ready) begin
        got = 1;
        rd  = useB ? ifB.rdata : ifA.rdata;
        er  = useB ? ifB.err : ifA.err;
      end else if (useB ? ifB.busy : ifA.busy) begin
        busyCnt++;
      end
    end
    driveBus(useB, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    if (!got) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc;
  int          busyCnt;

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    reset = 1'b0;
    driveBus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    driveBus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // reset held with req=1
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'd0, ifA.ready}, 32'd0);
    checkOutput("rst_err",   {31'd0, ifA.err},   32'd0);
    checkOutput("rst_rdata", ifA.rdata,          32'd0);
    checkOutput("rst_busy",  {31'd0, ifA.busy},  32'd1);
    reset = 1'b1;
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cyc++;
      if (ifA.ready) break;
    end
    checkOutput("rst_latency", cyc, 3);
    driveBus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // word store then load
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, cyc, busyCnt);
    checkOutput("st_rdata", rd, 32'd0);
    checkOutput("st_err",   {31'd0, er}, 32'd0);
    checkOutput("st_cyc",   cyc, 3);
    checkOutput("st_busy",  busyCnt, 3);
    applyStimulus(0, 1'b0, 1'b0, 32'h10, 32'h0, rd, er, cyc, busyCnt);
    checkOutput("ld_rdata", rd, 32'hDEADBEEF);
    checkOutput("ld_err",   {31'd0, er}, 32'd0);
    checkOutput("ld_busy",  busyCnt, 3);

    // byte lanes
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h11223344, rd, er, cyc, busyCnt);
    applyStimulus(0, 1'b1, 1'b1, 32'h22, 32'hFFFFFFAA, rd, er, cyc, busyCnt);
    checkOutput("sb_err", {31'd0, er}, 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 32'h20, 32'h0, rd, er, cyc, busyCnt);
    checkOutput("sb_lane2", rd, 32'h11AA3344);
    applyStimulus(0, 1'b1, 1'b1, 32'h23, 32'h00000055, rd, er, cyc, busyCnt);
    applyStimulus(0, 1'b0, 1'b0, 32'h20, 32'h0, rd, er, cyc, busyCnt);
    checkOutput("sb_lane3", rd, 32'h55AA3344);

    // misaligned load and address wrap
    applyStimulus(0, 1'b0, 1'b0, 32'h13, 32'h0, rd, er, cyc, busyCnt);
    checkOutput("mis_err",   {31'd0, er}, 32'd1);
    checkOutput("mis_rdata", rd, 32'd0);
    checkOutput("mis_cyc",   cyc, 3);
    applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h5, rd, er, cyc, busyCnt);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, rd, er, cyc, busyCnt);
    checkOutput("wrap_rdata", rd, 32'h5);

    // misaligned store must not write
    applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'hCAFEBABE, rd, er, cyc, busyCnt);
    applyStimulus(0, 1'b1, 1'b0, 32'h31, 32'h99999999, rd, er, cyc, busyCnt);
    checkOutput("mis_st_err", {31'd0, er}, 32'd1);
    applyStimulus(0, 1'b0, 1'b0, 32'h30, 32'h0, rd, er, cyc, busyCnt);
    checkOutput("mis_st_keep", rd, 32'hCAFEBABE);

    // reset pulse while a store sits in WAIT
    @(negedge clk);
    driveBus(0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h12345678);
    @(negedge clk);
    reset = 1'b0;
    driveBus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("midrst_ready", {31'd0, ifA.ready}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_idle", {31'd0, ifA.ready}, 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 32'h30, 32'h0, rd, er, cyc, busyCnt);
    checkOutput("midrst_rdata", rd, 32'hCAFEBABE);

    // zero-latency instance
    applyStimulus(1, 1'b1, 1'b0, 32'h4, 32'h000000A1, rd, er, cyc, busyCnt);
    checkOutput("l0_st_cyc", cyc, 1);
    applyStimulus(1, 1'b1, 1'b0, 32'h8, 32'h000000B2, rd, er, cyc, busyCnt);
    @(negedge clk);
    driveBus(1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    checkOutput("l0_rdy1",  {31'd0, ifB.ready}, 32'd1);
    checkOutput("l0_data1", ifB.rdata, 32'h000000A1);
    driveBus(1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    checkOutput("l0_gap",   {31'd0, ifB.ready}, 32'd0);
    checkOutput("l0_busy",  {31'd0, ifB.busy},  32'd1);
    @(negedge clk);
    checkOutput("l0_rdy2",  {31'd0, ifB.ready}, 32'd1);
    checkOutput("l0_data2", ifB.rdata, 32'h000000B2);
    driveBus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("l0_busy_noreq", {31'd0, ifB.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MIPS pipeline's data port; receives load/store requests from the processor's memory stage and answers them with a request/ready handshake.
- Inserts a configurable number of wait states so the pipeline must stall on data accesses.
- Supports word load, word store and byte store (sb).
- Sits beside the processor in the top level, in place of the zero-latency data memory.

Parameters:
- DEPTH, 64, number of 32-bit words in the storage array; power of two.
- LATENCY, 2, wait-state cycles between request acceptance and response; 0..15.
- IDX_W, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  1  processor data request; held stable until ready is seen
- we  in  1  1 = store, 0 = load
- sb  in  1  byte store; only meaningful with we=1
- addr  in  32  byte address
- wdata  in  32  store data; sb uses wdata[7:0]
- rdata  out  32  load data; valid only while ready=1
- ready  out  1  one-cycle response strobe
- err  out  1  misaligned word access flag; valid only while ready=1
- busy  out  1  stall request to the pipeline: req & ~ready, combinational

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0, ready=0, err=0, rdata=0.
  - Storage array is not cleared.
- States: IDLE, WAIT, DONE. Encoding comes from the package.
- IDLE:
  - On a rising edge with req=1, latch we, sb, addr, wdata.
  - Next state is WAIT with counter=LATENCY-1; if LATENCY=0, next state is DONE.
- WAIT:
  - Counter decrements each cycle; leave for DONE on the edge where the counter is 0.
  - req is ignored while in WAIT; request fields come only from the latched copies.
- DONE:
  - Lasts exactly one cycle with ready=1; always returns to IDLE on the next edge.
  - A request is never accepted in DONE, so back-to-back requests cost one IDLE cycle.
- Latency: an accept edge at cycle t gives ready=1 during cycle t+LATENCY+1. With LATENCY=2, ready comes 3 cycles after accept.
- Index: word index = latched addr[IDX_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Alignment: a word access (sb=0) with addr[1:0]!=0 is misaligned.
  - No array write.
  - rdata=0 and err=1 in DONE.
  - Still completes with normal latency.
- Word store: writes the full 32-bit word on the WAIT→DONE edge (or the IDLE→DONE edge when LATENCY=0).
- Byte store: little-endian lanes; addr[1:0]=n writes wdata[7:0] into bits [8n+7:8n] and leaves the other bytes unchanged. sb is never misaligned.
- Load: rdata is the full word at the index, registered on entry to DONE.
- Store responses: rdata=0, err=0.
- Read-after-write: a load following a store to the same word returns the updated data.
- Reset mid-operation: any pending store that has not reached its commit edge is dropped; return to IDLE with ready=0.
- busy: combinational; low whenever req=0.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - the BYTE_LANES=4 constant;
  - a function `lane_mask(addr[1:0])` returning a 4-bit byte enable.
- One sub-module, dmem_byte_merge: combinational merge of the old word, the store data and the byte-enable mask into the new word. It is shared by word stores (mask=4'hF) and byte stores.

Test Plan:
- Reset check: reset low for 2 cycles with req=1 → ready=0, err=0, rdata=0, busy=1. After release with LATENCY=2 → ready rises exactly 3 cycles after the first accept edge.
- Word store/load: store 0xDEADBEEF to 0x10, then load 0x10 → load ready with rdata=0xDEADBEEF, err=0. Each transaction shows busy for 3 cycles.
- Byte lanes: store 0x11223344 to 0x20, then sb 0xAA to 0x22, then load 0x20 → rdata=0x11AA3344.
- Misaligned and wrap: load from 0x13 → err=1, rdata=0. Store 0x5 to 0x100 (DEPTH=64), then load 0x0 → rdata=0x5.
- Reset mid-op: word store 0x12345678 to 0x30 on top of an existing 0xCAFEBABE; pulse reset during WAIT; then load 0x30 → rdata=0xCAFEBABE.
- LATENCY=0 build: consecutive loads → ready appears on the cycle after each accept, with one IDLE cycle between responses.
